// File: rtl/axis_selector_pkg.sv
// Shared field layout, lane state encoding and status bit offsets for the
// AXI-Stream selector matrix.
package axis_selector_pkg;

    localparam int IDX_LSB        = 0;
    localparam int IDX_W          = 5;
    localparam int EN_BIT         = 7;
    localparam int FIELD_W        = 8;
    localparam int STAT_BLANK_LSB = 0;
    localparam int STAT_RUN_LSB   = 16;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        RUN   = 2'd2
    } lane_state_t;

endpackage

// File: rtl/axis_selector_lane.sv
// One output lane: source mux, width conversion, IDLE/BLANK/RUN sequencer,
// settle counter and output register. AXIS_SELECTOR_HOLD_EN enables sample-and-hold tdata.
module axis_selector_lane
    import axis_selector_pkg::*;
#(
    parameter int NUM_S             = 16,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int SETTLE_CYCLES     = 4
) (
    input  logic                                a_clk,
    input  logic                                a_resetn,
    input  logic [NUM_S*SAXIS_TDATA_WIDTH-1:0]  i_tdata_p0,
    input  logic [NUM_S-1:0]                    i_tvalid_p0,
    input  logic                                i_commit,
    input  logic                                i_new_en,
    input  logic [IDX_W-1:0]                    i_new_idx,
    input  logic [IDX_W-1:0]                    i_cur_idx,
    output logic [MAXIS_TDATA_WIDTH-1:0]        o_tdata,
    output logic                                o_tvalid,
    output logic                                o_blank,
    output logic                                o_run
);
    localparam int SW = SAXIS_TDATA_WIDTH;
    localparam int MW = MAXIS_TDATA_WIDTH;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

    lane_state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic signed [SW-1:0]    w_src_data;
    logic                    w_src_valid;
    logic [MW-1:0]           w_conv;
    logic [MW-1:0]           w_sample;
    logic [MW-1:0]           w_tdata_nxt;
    logic                    w_tvalid_nxt;
    logic                    w_new_ok;
    logic                    w_idx_changed;
    logic [MW-1:0]           r_tdata_p1;
    logic                    r_tvalid_p1;
    logic                    r_blank_p1;
    logic                    r_run_p1;

    always_comb begin
        w_src_data  = '0;
        w_src_valid = 1'b0;
        for (int i = 0; i < NUM_S; i++) begin
            if (i_cur_idx == IDX_W'(i)) begin
                w_src_data  = i_tdata_p0[i*SW +: SW];
                w_src_valid = i_tvalid_p0[i];
            end
        end
    end

    generate
        if (MW > SW) begin : g_sext
            assign w_conv = {{(MW-SW){w_src_data[SW-1]}}, w_src_data};
        end else if (MW < SW) begin : g_trunc
            logic w_unused_lsb;
            assign w_conv       = w_src_data[SW-1 -: MW];
            assign w_unused_lsb = ^w_src_data[SW-MW-1:0];
        end else begin : g_pass
            assign w_conv = w_src_data;
        end
    endgenerate

`ifdef AXIS_SELECTOR_HOLD_EN
    assign w_sample = w_src_valid ? w_conv : r_tdata_p1;
`else
    assign w_sample = w_conv;
`endif

    // An out-of-range source index behaves exactly like a disable.
    assign w_new_ok      = i_new_en && (int'(i_new_idx) < NUM_S);
    assign w_idx_changed = (i_new_idx != i_cur_idx);

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_commit && !w_new_ok) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (i_commit && (r_state == IDLE || w_idx_changed)) begin
            if (SETTLE_CYCLES == 0) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_state_nxt = BLANK;
                w_cnt_nxt   = SETTLE_LD;
            end
        end else if (r_state == BLANK) begin
            if (r_cnt <= CNT_W'(1)) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_tdata_nxt  = '0;
        w_tvalid_nxt = 1'b0;
        case (r_state)
            BLANK: w_tdata_nxt = w_sample;
            RUN: begin
                w_tdata_nxt  = w_sample;
                w_tvalid_nxt = w_src_valid;
            end
            default: ;
        endcase
    end

    // Output register stage: data, valid and status leave together.
    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            r_tdata_p1  <= '0;
            r_tvalid_p1 <= 1'b0;
            r_blank_p1  <= 1'b0;
            r_run_p1    <= 1'b0;
        end else begin
            r_tdata_p1  <= w_tdata_nxt;
            r_tvalid_p1 <= w_tvalid_nxt;
            r_blank_p1  <= (r_state == BLANK);
            r_run_p1    <= (r_state == RUN);
        end
    end

    assign o_tdata  = r_tdata_p1;
    assign o_tvalid = r_tvalid_p1;
    assign o_blank  = r_blank_p1;
    assign o_run    = r_run_p1;

endmodule

// File: rtl/axis_selector_matrix.sv
// NUM_S-to-NUM_M AXI-Stream crosspoint with strobe-committed routing and
// post-switch tvalid blanking. Define AXIS_SELECTOR_HOLD_EN for sample-and-hold outputs.
module axis_selector_matrix
    import axis_selector_pkg::*;
#(
    parameter int NUM_S             = 16,
    parameter int NUM_M             = 6,
    parameter int SAXIS_TDATA_WIDTH = 32,
    parameter int MAXIS_TDATA_WIDTH = 32,
    parameter int SETTLE_CYCLES     = 4
) (
    input  logic                                a_clk,
    input  logic                                a_resetn,
    input  logic [NUM_S*SAXIS_TDATA_WIDTH-1:0]  S_AXIS_tdata,
    input  logic [NUM_S-1:0]                    S_AXIS_tvalid,
    input  logic [NUM_M*FIELD_W-1:0]            axis_selector,
    input  logic                                sel_update,
    output logic [NUM_M*MAXIS_TDATA_WIDTH-1:0]  M_AXIS_tdata,
    output logic [NUM_M-1:0]                    M_AXIS_tvalid,
    output logic [31:0]                         route_status
);
    localparam int SW = SAXIS_TDATA_WIDTH;
    localparam int MW = MAXIS_TDATA_WIDTH;

    logic [NUM_S*SW-1:0]     r_s_tdata_p0;
    logic [NUM_S-1:0]        r_s_tvalid_p0;
    logic [NUM_M*IDX_W-1:0]  r_route_idx;
    logic [NUM_M*IDX_W-1:0]  w_new_idx;
    logic [NUM_M-1:0]        w_new_en;
    logic [NUM_M-1:0]        w_blank;
    logic [NUM_M-1:0]        w_run;
    logic                    w_unused_rsvd;

    always_comb begin
        w_new_idx     = '0;
        w_new_en      = '0;
        w_unused_rsvd = 1'b0;
        for (int j = 0; j < NUM_M; j++) begin
            w_new_idx[j*IDX_W +: IDX_W] = axis_selector[j*FIELD_W + IDX_LSB +: IDX_W];
            w_new_en[j]                 = axis_selector[j*FIELD_W + EN_BIT];
            w_unused_rsvd = w_unused_rsvd ^ (^axis_selector[j*FIELD_W + IDX_W +: EN_BIT-IDX_W]);
        end
    end

    // Input register stage.
    always_ff @(posedge a_clk) begin
        r_s_tdata_p0 <= S_AXIS_tdata;
    end

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            r_s_tvalid_p0 <= '0;
            r_route_idx   <= '0;
        end else begin
            r_s_tvalid_p0 <= S_AXIS_tvalid;
            if (sel_update) begin
                r_route_idx <= w_new_idx;
            end
        end
    end

    for (genvar j = 0; j < NUM_M; j++) begin : g_lane
        axis_selector_lane #(
            .NUM_S             (NUM_S),
            .SAXIS_TDATA_WIDTH (SW),
            .MAXIS_TDATA_WIDTH (MW),
            .SETTLE_CYCLES     (SETTLE_CYCLES)
        ) u_lane (
            .a_clk       (a_clk),
            .a_resetn    (a_resetn),
            .i_tdata_p0  (r_s_tdata_p0),
            .i_tvalid_p0 (r_s_tvalid_p0),
            .i_commit    (sel_update),
            .i_new_en    (w_new_en[j]),
            .i_new_idx   (w_new_idx[j*IDX_W +: IDX_W]),
            .i_cur_idx   (r_route_idx[j*IDX_W +: IDX_W]),
            .o_tdata     (M_AXIS_tdata[j*MW +: MW]),
            .o_tvalid    (M_AXIS_tvalid[j]),
            .o_blank     (w_blank[j]),
            .o_run       (w_run[j])
        );
    end

    always_comb begin
        route_status = '0;
        route_status[STAT_BLANK_LSB +: NUM_M] = w_blank;
        route_status[STAT_RUN_LSB +: NUM_M]   = w_run;
    end

endmodule

// File: doc/axis_selector_matrix.md
# axis_selector_matrix

- Parametrised N-input to M-output AXI-Stream crosspoint for the RPSPMC signal-routing fabric.
- Successor to the fixed 16→6 selector.
- Adds:
  - atomic, strobe-committed routing updates;
  - per-output enable;
  - post-switch tvalid blanking, so downstream filters and decimators never see a mixed-source sample;
  - defined width conversion;
  - a routing status readback.
- Sits between the ADC/DSP stream sources and the DMA/monitor sinks.

## Interface
- NUM_S, 16: number of slave streams, 2..32.
- NUM_M, 6: number of master streams, 1..8.
- SAXIS_TDATA_WIDTH, 32: input sample width.
- MAXIS_TDATA_WIDTH, 32: output sample width.
- SETTLE_CYCLES, 4: tvalid blanking length after a route change, 0..255.
- a_clk  in  1  single clock; all logic on rising edge.
- a_resetn  in  1  reset, synchronous, active-low.
- S_AXIS_tdata  in  NUM_S*SAXIS_TDATA_WIDTH  packed inputs; stream i occupies slice i.
- S_AXIS_tvalid  in  NUM_S  per-input valid.
- axis_selector  in  NUM_M*8  one byte per output j:
  - bits [4:0]: source index;
  - bit 7: enable;
  - bits [6:5]: reserved, ignored.
- sel_update  in  1  commit strobe for axis_selector.
- M_AXIS_tdata  out  NUM_M*MAXIS_TDATA_WIDTH  packed outputs.
- M_AXIS_tvalid  out  NUM_M  per-output valid.
- route_status  out  32  bits [NUM_M-1:0] = output blanking; bits [NUM_M+15:16] = output enabled-and-running.

## Operation
- Input stage: registers all tdata and tvalid every cycle; no backpressure, no tready.
- Active route register:
  - loaded from axis_selector on any cycle with sel_update=1;
  - otherwise held.
- axis_selector changes without sel_update have no effect.
- Per-output state machine, with states IDLE, BLANK and RUN:
  - IDLE: the output is disabled. tdata=0, tvalid=0.
  - IDLE→BLANK: on a commit with enable=1.
  - BLANK: counter loaded with SETTLE_CYCLES. tdata follows the new source, tvalid=0. The counter decrements each cycle.
  - BLANK→RUN: when the counter reaches 0.
  - SETTLE_CYCLES=0: a commit goes directly to RUN.
  - RUN: tdata and tvalid follow the selected source.
  - RUN→BLANK: on a commit where this output's index changed.
  - Commit with an unchanged byte: no state change and no blanking. Other outputs' changes do not disturb this output.
  - Any state→IDLE: on a commit with enable=0.
  - Commit during BLANK with a changed index: the counter reloads to SETTLE_CYCLES.
- Index ≥ NUM_S: treated as disabled. The output goes to IDLE and route_status shows it not running.
- Width rule:
  - MAXIS > SAXIS: sign-extend.
  - MAXIS < SAXIS: take the MSBs (arithmetic truncation).
  - Equal widths: pass through.
- Reset, a_resetn=0 at an edge:
  - active route register := 0, so all outputs are in IDLE;
  - all counters := 0;
  - M_AXIS_tdata := 0, M_AXIS_tvalid := 0, route_status := 0.
- Reset overrides a simultaneous sel_update.

## Timing
- Data latency, input to output: 2 cycles. One cycle is the input register; one cycle is the output register.
- sel_update high at edge k:
  - the new route is active at edge k;
  - the output register reflects the new source at edge k+1;
  - tvalid stays 0 for edges k+1 .. k+SETTLE_CYCLES;
  - the first valid output is at edge k+SETTLE_CYCLES+1, provided the source tvalid=1.
- route_status is registered and aligned with M_AXIS_tvalid.
- Reset release: outputs stay IDLE until the first commit.

## Configuration
- AXIS_SELECTOR_HOLD_EN defined: sample-and-hold.
  - In RUN, output tdata updates only on cycles where the selected source tvalid=1; otherwise it keeps the last value.
  - tvalid is not held; it still mirrors the source.
  - In BLANK, tdata is held, and is loaded with the first valid sample of the new source.
- AXIS_SELECTOR_HOLD_EN not defined: tdata is transparent and registered from the source every cycle, whatever the source tvalid.

## Structure
- Package axis_selector_pkg:
  - selector byte field constants: IDX_LSB=0, IDX_W=5, EN_BIT=7, FIELD_W=8;
  - the state enum {IDLE, BLANK, RUN};
  - the route_status bit offsets: blanking at 0, running at 16.
- Sub-module axis_selector_lane: one instance per output.
  - Contents: mux, width converter, state machine, settle counter and hold register.
  - The top level holds the input register, the route register, the commit logic and the status packing.

## Test plan
- **Reset and first commit.** Reset, then commit axis_selector byte0=0x83 (enable, src 3), SETTLE_CYCLES=4, with S3 driving an incrementing count and tvalid=1.
  - M1 tvalid=0 for 4 cycles after commit+1, then 1.
  - M1 tdata equals the S3 value from 2 cycles earlier.
- **Switch while running.** Switch byte0 from 0x83 to 0x85 while running.
  - M1 blanks 4 cycles, then carries S5.
  - Outputs M2..M6, whose bytes are unchanged, keep tvalid=1 throughout.
- **Disable and out-of-range index.**
  - Commit byte1=0x03 (enable=0): M2 tdata=0, tvalid=0, route_status bit17=0.
  - Commit index 20 with NUM_S=16: same result.
- **Width conversion.**
  - SAXIS=16, MAXIS=32, input 0x8001 → output 0xFFFF8001.
  - SAXIS=32, MAXIS=16, input 0x12345678 → output 0x1234.
- **Recommit during blanking and reset.**
  - Recommit a changed index 2 cycles into BLANK: the counter restarts and valid is delayed to 4 cycles after the second commit.
  - Assert a_resetn=0 mid-BLANK: all outputs are 0 at the next edge.
- **Hold mode.** With AXIS_SELECTOR_HOLD_EN defined, source tvalid toggles 1,0,0,1 with data A,B,C,D.
  - Output tdata is A,A,A,D.
  - Output tvalid mirrors the source 1,0,0,1.
